// File: rtl/alu_mem_stage_pkg.sv
// Shared constants for the ALU-to-memory pipeline stage.
// Holds the access-size encodings, default widths and the width of one stage entry.
package alu_mem_stage_pkg;

    localparam logic [1:0] MEM_BYTE   = 2'd0;
    localparam logic [1:0] MEM_HALF   = 2'd1;
    localparam logic [1:0] MEM_WORD   = 2'd2;
    localparam logic [1:0] MEM_DOUBLE = 2'd3;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;

    // Entry = address, store data, byte enables, rd/wr/uns, size, reg_write, wb_addr, misaligned.
    function automatic int entry_w(int dw, int rw);
        return 2 * dw + dw / 8 + rw + 7;
    endfunction

endpackage

// File: rtl/alu_mem_stage_store_align.sv
// Store lane alignment: replicates rs2 to the access size, shifts it into its
// byte lanes, builds byte enables and flags misaligned accesses.
module mem_store_align
    import alu_mem_stage_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ALIGN_CHECK = 1,
    parameter int NB          = DATA_W / 8,
    parameter int OFF_W       = $clog2(NB)
) (
    input  logic [OFF_W-1:0]  i_off,
    input  logic [1:0]        i_size,
    input  logic [DATA_W-1:0] i_rs2,
    input  logic              i_write,
    output logic [DATA_W-1:0] o_store_data,
    output logic [NB-1:0]     o_byte_en,
    output logic              o_misaligned
);

    logic [DATA_W-1:0] w_rep;
    logic [7:0]        w_mask;
    logic [15:0]       w_be_wide;
    logic [2:0]        w_off3;
    logic              w_mis_raw;

    always_comb begin
        w_rep     = i_rs2;
        w_mask    = 8'h01;
        w_mis_raw = 1'b0;
        w_off3    = 3'(i_off);
        case (i_size)
            MEM_BYTE: begin
                w_rep  = {NB{i_rs2[7:0]}};
                w_mask = 8'h01;
            end
            MEM_HALF: begin
                w_rep     = {(NB/2){i_rs2[15:0]}};
                w_mask    = 8'h03;
                w_mis_raw = w_off3[0];
            end
            MEM_WORD: begin
                w_rep     = {(NB/4){i_rs2[31:0]}};
                w_mask    = 8'h0F;
                w_mis_raw = (w_off3[1:0] != 2'b00);
            end
            default: begin
                w_rep     = i_rs2;
                w_mask    = 8'hFF;
                // A 32-bit datapath has no double-word access at all.
                w_mis_raw = (DATA_W == 32) || (w_off3 != 3'b000);
            end
        endcase
        w_be_wide = {8'h00, w_mask} << i_off;
    end

    assign o_store_data = w_rep << {i_off, 3'b000};
    assign o_misaligned = (ALIGN_CHECK != 0) && w_mis_raw;
    assign o_byte_en    = (i_write && !o_misaligned) ? w_be_wide[NB-1:0] : '0;

endmodule

// File: rtl/alu_mem_stage.sv
// Elastic ALU->MEM pipeline stage: main + skid entry with a registered ready,
// flush, store lane alignment and misalignment suppression.
module alu_mem_stage
    import alu_mem_stage_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int ALIGN_CHECK = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     alu_result_in,
    input  logic [DATA_W-1:0]     rs2_in,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic [1:0]            mem_size_in,
    input  logic                  mem_unsigned_in,
    input  logic                  reg_write_in,
    input  logic [REG_ADDR_W-1:0] wb_addr_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     data_out,
    output logic [DATA_W-1:0]     store_data_out,
    output logic [DATA_W/8-1:0]   byte_en_out,
    output logic                  mem_read_out,
    output logic                  mem_write_out,
    output logic                  mem_unsigned_out,
    output logic [1:0]            mem_size_out,
    output logic                  reg_write_out,
    output logic [REG_ADDR_W-1:0] wb_addr_out,
    output logic                  misaligned_out
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int EW    = entry_w(DATA_W, REG_ADDR_W);

    typedef struct packed {
        logic [DATA_W-1:0]     data;
        logic [DATA_W-1:0]     sdata;
        logic [NB-1:0]         be;
        logic                  rd;
        logic                  wr;
        logic                  uns;
        logic [1:0]            size;
        logic                  rw;
        logic [REG_ADDR_W-1:0] wb;
        logic                  mis;
    } entry_t;

    logic [EW-1:0]     r_main, r_skid;
    logic              r_main_v, r_skid_v;
    logic [DATA_W-1:0] w_sdata;
    logic [NB-1:0]     w_be;
    logic              w_mis, w_acc, w_pop;
    entry_t            w_in, w_head;

    mem_store_align #(
        .DATA_W      (DATA_W),
        .ALIGN_CHECK (ALIGN_CHECK)
    ) u_align (
        .i_off        (alu_result_in[OFF_W-1:0]),
        .i_size       (mem_size_in),
        .i_rs2        (rs2_in),
        .i_write      (mem_write_in),
        .o_store_data (w_sdata),
        .o_byte_en    (w_be),
        .o_misaligned (w_mis)
    );

    // Misaligned entries keep the address for trap reporting but lose all side effects.
    always_comb begin
        w_in.data  = alu_result_in;
        w_in.sdata = w_sdata;
        w_in.be    = w_be;
        w_in.rd    = mem_read_in && !w_mis;
        w_in.wr    = mem_write_in && !w_mis;
        w_in.uns   = mem_unsigned_in;
        w_in.size  = mem_size_in;
        w_in.rw    = reg_write_in && !w_mis;
        w_in.wb    = wb_addr_in;
        w_in.mis   = w_mis;
    end

    assign in_ready = !r_skid_v && !rst;
    assign w_acc    = in_valid && in_ready;
    assign w_pop    = r_main_v && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_main   <= '0;
            r_skid   <= '0;
        end else if (flush) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (!r_main_v || w_pop) begin
            if (r_skid_v) begin
                r_main   <= r_skid;
                r_main_v <= 1'b1;
                r_skid   <= w_in;
                r_skid_v <= w_acc;
            end else begin
                if (w_acc)
                    r_main <= w_in;
                r_main_v <= w_acc;
            end
        end else if (w_acc) begin
            r_skid   <= w_in;
            r_skid_v <= 1'b1;
        end
    end

    assign w_head           = r_main;
    assign out_valid        = r_main_v;
    assign data_out         = w_head.data;
    assign store_data_out   = w_head.sdata;
    assign byte_en_out      = w_head.be;
    assign mem_read_out     = w_head.rd;
    assign mem_write_out    = w_head.wr;
    assign mem_unsigned_out = w_head.uns;
    assign mem_size_out     = w_head.size;
    assign reg_write_out    = w_head.rw;
    assign wb_addr_out      = w_head.wb;
    assign misaligned_out   = w_head.mis;

endmodule

// File: tb/tb_alu_mem_stage.sv
// Bench for alu_mem_stage: directed scenarios plus random traffic against a
// queue-based reference, with one ALIGN_CHECK=1 and one ALIGN_CHECK=0 instance.
module tb_alu_mem_stage;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] sdata;
        logic [3:0]  be;
        logic        rd, wr, uns, rw, mis;
        logic [1:0]  size;
        logic [4:0]  wb;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] addr, rs2;
    logic        rd, wr, uns, rw;
    logic [1:0]  size;
    logic [4:0]  wb;

    logic        a_in_ready, a_out_valid, a_rd, a_wr, a_uns, a_rw, a_mis;
    logic [31:0] a_data, a_sdata;
    logic [3:0]  a_be;
    logic [1:0]  a_size;
    logic [4:0]  a_wb;
    logic        b_in_ready, b_out_valid, b_rd, b_wr, b_uns, b_rw, b_mis;
    logic [31:0] b_data, b_sdata;
    logic [3:0]  b_be;
    logic [1:0]  b_size;
    logic [4:0]  b_wb;

    int   n_chk = 0;
    int   n_err = 0;
    ent_t qa[$];
    ent_t qb[$];

    always #5 clk = ~clk;

    alu_mem_stage #(.DATA_W(32), .REG_ADDR_W(5), .ALIGN_CHECK(1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .alu_result_in(addr), .rs2_in(rs2), .mem_read_in(rd), .mem_write_in(wr),
        .mem_size_in(size), .mem_unsigned_in(uns), .reg_write_in(rw), .wb_addr_in(wb),
        .out_valid(a_out_valid), .out_ready(out_ready), .data_out(a_data),
        .store_data_out(a_sdata), .byte_en_out(a_be), .mem_read_out(a_rd),
        .mem_write_out(a_wr), .mem_unsigned_out(a_uns), .mem_size_out(a_size),
        .reg_write_out(a_rw), .wb_addr_out(a_wb), .misaligned_out(a_mis));

    alu_mem_stage #(.DATA_W(32), .REG_ADDR_W(5), .ALIGN_CHECK(0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .alu_result_in(addr), .rs2_in(rs2), .mem_read_in(rd), .mem_write_in(wr),
        .mem_size_in(size), .mem_unsigned_in(uns), .reg_write_in(rw), .wb_addr_in(wb),
        .out_valid(b_out_valid), .out_ready(out_ready), .data_out(b_data),
        .store_data_out(b_sdata), .byte_en_out(b_be), .mem_read_out(b_rd),
        .mem_write_out(b_wr), .mem_unsigned_out(b_uns), .mem_size_out(b_size),
        .reg_write_out(b_rw), .wb_addr_out(b_wb), .misaligned_out(b_mis));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference entry from the lane/alignment rules using plain arithmetic.
    function automatic ent_t model(input bit align_check);
        ent_t e;
        int   nbytes = 1 << size;
        int   nrep   = (nbytes > 4) ? 4 : nbytes;
        int   off    = addr % 4;
        logic [31:0] rep = 0;
        logic [63:0] be_wide;
        for (int i = 0; i < 4; i++)
            rep |= ((rs2 >> (8 * (i % nrep))) & 32'hFF) << (8 * i);
        be_wide = ((64'd1 << nbytes) - 1) << off;
        e.mis   = align_check && (size == 2'd3 || (addr % nbytes) != 0);
        e.data  = addr;
        e.sdata = rep << (8 * off);
        e.be    = (wr && !e.mis) ? be_wide[3:0] : 4'h0;
        e.rd    = rd && !e.mis;
        e.wr    = wr && !e.mis;
        e.rw    = rw && !e.mis;
        e.uns   = uns;
        e.size  = size;
        e.wb    = wb;
        return e;
    endfunction

    task automatic check_state();
        chk("a_out_valid", a_out_valid, qa.size() != 0);
        chk("b_out_valid", b_out_valid, qb.size() != 0);
        chk("a_in_ready", a_in_ready, !rst && qa.size() < 2);
        chk("b_in_ready", b_in_ready, !rst && qb.size() < 2);
        if (qa.size() != 0)
            chk("a_head", {a_data, a_sdata, a_be, a_rd, a_wr, a_uns, a_rw, a_mis, a_size, a_wb}, qa[0]);
        if (qb.size() != 0)
            chk("b_head", {b_data, b_sdata, b_be, b_rd, b_wr, b_uns, b_rw, b_mis, b_size, b_wb}, qb[0]);
    endtask

    // Advance the reference by one edge with the currently driven inputs, then check.
    task automatic tick();
        bit   rdy = !rst && qa.size() < 2;
        bit   acc = in_valid && rdy;
        bit   pop = qa.size() != 0 && out_ready;
        ent_t ea  = model(1'b1);
        ent_t eb  = model(1'b0);
        if (rst || flush) begin
            qa.delete();
            qb.delete();
        end else begin
            if (pop) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
            if (acc) begin
                qa.push_back(ea);
                qb.push_back(eb);
            end
        end
        @(negedge clk);
        check_state();
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic r, input logic w, input logic [1:0] s, input logic rwi,
                         input logic [4:0] wbi);
        in_valid = v; addr = a; rs2 = d; rd = r; wr = w; size = s; rw = rwi; wb = wbi;
        uns = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0);
        tick();
        tick();
        chk("rst_data", a_data, 0);
        chk("rst_wb", a_wb, 0);
        rst = 1'b0;

        // Streaming, 1 entry/cycle.
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 32'(i), 1'b1, 1'b0, 2'd2, 1'b1, 5'(i));
            tick();
            chk("stream_wb", a_wb, i);
            chk("stream_rdy", a_in_ready, 1);
        end
        in_valid = 1'b0;
        tick();

        // Backpressure: A then B, outputs hold A, then drain in order.
        out_ready = 1'b0;
        drive(1'b1, 32'h200, 32'hA, 1'b1, 1'b0, 2'd2, 1'b1, 5'd5);
        tick();
        drive(1'b1, 32'h204, 32'hB, 1'b1, 1'b0, 2'd2, 1'b1, 5'd6);
        tick();
        chk("bp_rdy_low", a_in_ready, 0);
        drive(1'b1, 32'h208, 32'hC, 1'b1, 1'b0, 2'd2, 1'b1, 5'd7);
        tick();
        chk("bp_hold_A", a_wb, 5);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("bp_then_B", a_wb, 6);
        tick();
        chk("bp_drained", a_out_valid, 0);

        // Store lane placement.
        drive(1'b1, 32'h102, 32'h0000BEEF, 1'b0, 1'b1, 2'd1, 1'b0, 5'd0);
        tick();
        chk("half_be", a_be, 4'b1100);
        chk("half_sd", a_sdata, 32'hBEEF0000);
        drive(1'b1, 32'h3, 32'h5A, 1'b0, 1'b1, 2'd0, 1'b0, 5'd0);
        tick();
        chk("byte_be", a_be, 4'b1000);
        chk("byte_sd", a_sdata, 32'h5A000000);

        // Misaligned word load.
        drive(1'b1, 32'h6, 32'h0, 1'b1, 1'b0, 2'd2, 1'b1, 5'd9);
        tick();
        chk("mis_flag", a_mis, 1);
        chk("mis_rd", a_rd, 0);
        chk("mis_rw", a_rw, 0);
        chk("mis_addr", a_data, 32'h6);
        chk("nochk_flag", b_mis, 0);
        chk("nochk_rd", b_rd, 1);
        in_valid = 1'b0;
        tick();

        // Flush with both entries held and a same-cycle incoming entry.
        out_ready = 1'b0;
        drive(1'b1, 32'h300, 32'h1, 1'b1, 1'b0, 2'd2, 1'b1, 5'd11);
        tick();
        wb = 5'd12;
        tick();
        flush = 1'b1; wb = 5'd13;
        tick();
        chk("flush_vld", a_out_valid, 0);
        chk("flush_rdy", a_in_ready, 1);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("flush_drop", a_out_valid, 0);

        // Reset mid-stream.
        drive(1'b1, 32'h400, 32'hFFFF, 1'b0, 1'b1, 2'd2, 1'b1, 5'd14);
        tick();
        rst = 1'b1;
        tick();
        chk("rst_vld", a_out_valid, 0);
        chk("rst_all0", {a_data, a_sdata, a_be, a_rd, a_wr, a_uns, a_rw, a_mis, a_size, a_wb}, 0);
        chk("rst_rdy", a_in_ready, 0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rdy_after_rst", a_in_ready, 1);
        tick();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(299) == 0);
            flush     = ($urandom_range(39) == 0);
            out_ready = ($urandom_range(2) != 0);
            drive($urandom_range(3) != 0, $urandom, $urandom, 1'($urandom), 1'($urandom),
                  2'($urandom), 1'($urandom), 5'($urandom));
            uns = 1'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
